// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense chosen by PARITY_ODD).
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int              CW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;
`endif

  state_t                state, state_nx;
  logic [DATA_BITS-1:0]  shift, shift_nx;
  logic [CW-1:0]         bit_cnt, bit_cnt_nx;
  logic                  stop_cnt, stop_cnt_nx;
  logic                  tx_nx, done_nx;
`ifdef UART_TX_PARITY_EN
  logic                  parity, parity_nx;
`endif

  always_comb begin
    state_nx    = state;
    shift_nx    = shift;
    bit_cnt_nx  = bit_cnt;
    stop_cnt_nx = stop_cnt;
    done_nx     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nx   = parity;
`endif
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shift_nx  = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_nx = (^tx_data) ^ PARITY_ODD;
`endif
          state_nx  = SYNC;
        end
      end
      // SYNC aligns the frame to the tick grid so the start bit gets a full period
      SYNC:  if (baud_tick) state_nx = START;
      START: if (baud_tick) state_nx = DATA;
      DATA: begin
        if (baud_tick) begin
          shift_nx = {1'b0, shift[DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nx = '0;
`ifdef UART_TX_PARITY_EN
            state_nx   = PARITY;
`else
            state_nx   = STOP;
`endif
          end else begin
            bit_cnt_nx = bit_cnt + CW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_tick) state_nx = STOP;
`endif
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt == LAST_STOP) begin
            stop_cnt_nx = 1'b0;
            state_nx    = IDLE;
            done_nx     = 1'b1;
          end else begin
            stop_cnt_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // line level is decided from the upcoming state so tx itself is a flop
    tx_nx = 1'b1;
    case (state_nx)
      START:  tx_nx = 1'b0;
      DATA:   tx_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nx = parity_nx;
`endif
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      shift    <= shift_nx;
      bit_cnt  <= bit_cnt_nx;
      stop_cnt <= stop_cnt_nx;
      tx       <= tx_nx;
      tx_ready <= (state_nx == IDLE);
      tx_busy  <= (state_nx != IDLE);
      tx_done  <= done_nx;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity <= 1'b0;
    else     parity <= parity_nx;
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: random and directed frames checked against a bit-list model of the frame.
// Runs one instance with STOP_BITS=1 and one with STOP_BITS=2.
module tb_uart_tx;

  localparam bit PODD = 1'b0;

  logic       clk, rst, baud_tick;
  logic [7:0] tx_data;
  logic       valid1, valid2;
  logic       tx1, ready1, busy1, done1;
  logic       tx2, ready2, busy2, done2;
  logic       sel;
  logic       tx_s, ready_s, busy_s, done_s;
  int         baud;
  int         vectors, miscompares;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PODD)) u1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid1),
    .tx_ready(ready1), .tx(tx1), .tx_busy(busy1), .tx_done(done1));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(PODD)) u2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid2),
    .tx_ready(ready2), .tx(tx2), .tx_busy(busy2), .tx_done(done2));

  assign tx_s    = sel ? tx2    : tx1;
  assign ready_s = sel ? ready2 : ready1;
  assign busy_s  = sel ? busy2  : busy1;
  assign done_s  = sel ? done2  : done1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // free-running tick, one pulse every 'baud' cycles
  initial begin
    int tcnt;
    tcnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      if (tcnt >= baud) begin
        baud_tick = 1'b1;
        tcnt = 0;
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (ready_s !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      vectors++; miscompares++;
      $display("FAIL send_ready: tx_ready=%b expected 1", ready_s);
    end
    tx_data = d;
    if (sel) valid2 = 1'b1; else valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  // model: the frame is simply a list of line levels, one per tick period
  task automatic check_frame(input logic [7:0] d, input string name);
    logic exp_q[$];
    int   n, k, done_cnt, done_cyc, stops;
    stops = sel ? 2 : 1;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back((^d) ^ PODD);
`endif
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    n = exp_q.size();

    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx_s !== 1'b0 && k < 4 * baud + 8);
    if (tx_s !== 1'b0) begin
      vectors++; miscompares++;
      $display("FAIL %s start: tx=%b expected 0 within %0d cycles", name, tx_s, 4 * baud + 8);
      return;
    end

    done_cnt = 0;
    done_cyc = -1;
    for (int c = 0; c <= n * baud; c++) begin
      if (c > 0) @(negedge clk);
      if (c % baud == baud / 2) begin
        vectors++;
        if (tx_s !== exp_q[c / baud]) begin
          miscompares++;
          $display("FAIL %s bit%0d: tx=%b expected %b", name, c / baud, tx_s, exp_q[c / baud]);
        end
      end
      if (done_s === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    vectors++;
    if (done_cnt !== 1 || done_cyc !== n * baud) begin
      miscompares++;
      $display("FAIL %s done: pulses=%0d at cycle %0d expected 1 at cycle %0d",
               name, done_cnt, done_cyc, n * baud);
    end
    vectors++;
    if (ready_s !== 1'b1 || busy_s !== 1'b0) begin
      miscompares++;
      $display("FAIL %s end_state: ready=%b busy=%b expected 1 0", name, ready_s, busy_s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid1 = 1'b1;
    valid2 = 1'b1;
    tx_data = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({tx1, ready1, busy1, done1, tx2, busy2} !== 6'b110010) begin
        miscompares++;
        $display("FAIL reset_outputs: tx/ready/busy/done=%b%b%b%b tx2/busy2=%b%b expected 1100 10",
                 tx1, ready1, busy1, done1, tx2, busy2);
      end
    end
    valid1 = 1'b0;
    valid2 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_accept: busy1=%b busy2=%b expected 0 0", busy1, busy2);
    end
  endtask

  task automatic test_single_55();
    sel = 1'b0;
    send(8'h55);
    check_frame(8'h55, "single_55");
  endtask

  task automatic test_pattern_a3();
    sel = 1'b0;
    send(8'hA3);
    check_frame(8'hA3, "pattern_a3");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    @(negedge clk);
    tx_data = 8'h0F;
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'hF0;
    check_frame(8'h0F, "b2b_first");
    @(negedge clk);
    vectors++;
    if (busy1 !== 1'b1 || ready1 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b ready=%b one cycle after done, expected 1 0", busy1, ready1);
    end
    valid1 = 1'b0;
    check_frame(8'hF0, "b2b_second");
  endtask

  task automatic test_stop2();
    sel = 1'b1;
    send(8'h00);
    check_frame(8'h00, "stop2_00");
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int k, done_seen;
    sel = 1'b0;
    send(8'h00);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx1 !== 1'b0 && k < 4 * baud + 8);
    repeat (4 * baud + baud / 2) @(negedge clk);
    vectors++;
    if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_before: tx=%b busy=%b expected 0 1", tx1, busy1);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_async: tx=%b busy=%b ready=%b expected 1 0 1", tx1, busy1, ready1);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (12 * baud) begin
      @(negedge clk);
      if (done1 === 1'b1 || tx1 !== 1'b1) done_seen++;
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++;
      $display("FAIL midrst_quiet: %0d cycles with tx_done or tx low, expected 0", done_seen);
    end
    send(8'h81);
    check_frame(8'h81, "after_rst_81");
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      baud = $urandom_range(3, 12);
      sel  = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      send(d);
      check_frame(d, "random");
    end
    sel = 1'b0;
    baud = 16;
  endtask

  initial begin
    rst = 1'b1;
    valid1 = 1'b0;
    valid2 = 1'b0;
    tx_data = 8'h00;
    sel = 1'b0;
    baud = 16;
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_55();
    test_pattern_a3();
    test_back_to_back();
    test_stop2();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; consumes the 1x baud_tick from the baud generator and serialises one parallel byte per frame onto the tx line.
- Frame: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
- Sits between the host-side byte source (valid/ready handshake) and the pad; pairs with the baud generator instance driven by the same clock.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
baud_tick  input  1  one-cycle pulse per bit period, from the baud generator
tx_data  input  DATA_BITS  byte to send; sampled only on handshake
tx_valid  input  1  source has a byte
tx_ready  output  1  block can accept a byte; high only in IDLE
tx  output  1  serial line; idle high
tx_busy  output  1  high whenever state is not IDLE
tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (async, rst=1): state IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0; shift register and counters cleared. Asserting rst mid-frame abandons the frame; tx returns high immediately; no tx_done is issued.
- All outputs are registered. tx_ready = (state==IDLE).
- Handshake: transfer occurs on a clk edge with tx_valid & tx_ready. tx_data is latched into the shift register; state moves IDLE->SYNC. tx_data is ignored at all other times.
- SYNC: tx=1; waits for the next baud_tick, then moves to START. A baud_tick coincident with the accept cycle does not count. This gives every bit exactly one full tick period.
- START: tx=0 for one tick period; on baud_tick -> DATA.
- DATA: tx = shift[0]. On each baud_tick, shift right and increment bit_cnt. After DATA_BITS ticks -> PARITY if compiled in, otherwise -> STOP. bit_cnt width is clog2(DATA_BITS); it resets to 0 on leaving DATA.
- PARITY (feature only): tx = parity bit for one tick period; on baud_tick -> STOP.
- STOP: tx=1 for STOP_BITS tick periods, counted by stop_cnt. On the final tick -> IDLE, with tx_done=1 for exactly that one cycle and tx_ready=1 in the same cycle.
- Back-to-back frames: if tx_valid is held high, the next byte is accepted on the first IDLE cycle, i.e. one cycle after tx_done. The line stays high through IDLE and SYNC, so the inter-frame gap is 1 cycle plus up to one tick period.
- baud_tick in IDLE is ignored. tx_valid during a frame is ignored and tx_ready stays low.
- Frame length from the first START cycle to tx_done: (1 + DATA_BITS + P + STOP_BITS) tick periods, where P=1 with parity compiled in and 0 without.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state is present. The parity bit is the XOR of the latched data bits, inverted when PARITY_ODD=1. It is computed at accept time and held in a register.
- Undefined: no PARITY state and no parity logic. PARITY_ODD has no effect.

Test Plan:
- Reset: hold rst=1 for 3 cycles with tx_valid=1 -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; nothing accepted.
- Single byte, baud_tick every 16 cycles, send 0x55 (no parity) -> tx sequence per 16-cycle bit: 0,1,0,1,0,1,0,1,0,1. tx_done pulses once, 160 cycles after the first START cycle.
- Parity (UART_TX_PARITY_EN defined), send 0xA3 -> data bits 1,1,0,0,0,1,0,1. Parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1, followed by stop 1.
- Back-to-back: tx_valid held high with 0x0F then 0xF0 -> second accept exactly 1 cycle after the first tx_done. Second frame bits are 0,0,0,0,0,1,1,1,1,1. No glitch low on tx between the two frames.
- STOP_BITS=2, send 0x00 -> tx low for 9 bit periods (start plus 8 data bits), then high for 2 bit periods before tx_done.
- Reset mid-frame: assert rst during the 4th data bit of 0x00 -> tx goes to 1 the same cycle and no tx_done. After release, a new byte 0x81 transmits correctly as 0,1,0,0,0,0,0,0,1,1.
